// File: rtl/load_align_unit_pkg.sv
// load_align_unit_pkg: shared funct3 codes (loads and stores) and load FSM state encoding
package load_align_unit_pkg;

   typedef logic [2:0] func3_t;

   localparam func3_t FNC_LB  = 3'd0;
   localparam func3_t FNC_LH  = 3'd1;
   localparam func3_t FNC_LW  = 3'd2;
   localparam func3_t FNC_LBU = 3'd4;
   localparam func3_t FNC_LHU = 3'd5;
   localparam func3_t FNC_SB  = 3'd0;
   localparam func3_t FNC_SH  = 3'd1;
   localparam func3_t FNC_SW  = 3'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DATA1 = 2'd1;
   localparam logic [1:0] ST_DATA2 = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   function automatic logic is_misaligned(func3_t f3, logic [1:0] off);
      return ((f3 == FNC_LH || f3 == FNC_LHU) && off[0]) || (f3 == FNC_LW && off != 2'd0);
   endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// load_align_unit_if: load request / response handshake bundle
interface load_align_unit_if #(
   parameter int DWIDTH = 32,
   parameter int TAG_W  = 5
);
   import load_align_unit_pkg::*;

   logic              req_valid;
   logic              req_ready;
   func3_t            req_func3;
   logic [31:0]       req_addr;
   logic [TAG_W-1:0]  req_rd;
   logic              resp_valid;
   logic              resp_ready;
   logic [DWIDTH-1:0] resp_data;
   logic [TAG_W-1:0]  resp_rd;
   logic              resp_misaligned;

   modport master (
      output req_valid, req_func3, req_addr, req_rd, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_rd, resp_misaligned
   );

   modport slave (
      input  req_valid, req_func3, req_addr, req_rd, resp_ready,
      output req_ready, resp_valid, resp_data, resp_rd, resp_misaligned
   );

endinterface

// File: rtl/load_align_unit_extract.sv
// load_extract: pick byte/half/word at a byte offset from a 64-bit window and extend it
module load_extract
   import load_align_unit_pkg::*;
(
   input  func3_t      func3,
   input  logic [1:0]  offset,
   input  logic [63:0] window,
   output logic [31:0] result
);

   logic [31:0] w;

   assign w = 32'(window >> {offset, 3'b000});

   assign result = func3 == FNC_LB  ? {{24{w[7]}}, w[7:0]}   :
                   func3 == FNC_LBU ? {24'h0, w[7:0]}        :
                   func3 == FNC_LH  ? {{16{w[15]}}, w[15:0]} :
                   func3 == FNC_LHU ? {16'h0, w[15:0]}       :
                   func3 == FNC_LW  ? w                      :
                                      window[31:0];

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: load FSM issuing 1-cycle-latency word reads and returning aligned, extended data (option: LOAD_UNIT_MISALIGNED_EN)
module load_align_unit
   import load_align_unit_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int MEM_AWIDTH = 14,
   parameter int TAG_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   load_align_unit_if.slave      bus,
   output logic                  mem_en,
   output logic [MEM_AWIDTH-1:0] mem_addr,
   input  logic [DWIDTH-1:0]     mem_dout
);

   logic [1:0]            state;
   func3_t                f3_q;
   logic [1:0]            off_q;
   logic [TAG_W-1:0]      rd_q;
   logic [MEM_AWIDTH-1:0] waddr_q;
   logic [DWIDTH-1:0]     word1_q;
   logic [DWIDTH-1:0]     data_q;
   logic                  mis_q;
   logic                  need2;
   logic                  mis_flag;
   logic [2*DWIDTH-1:0]   window;
   logic [DWIDTH-1:0]     fmt;

`ifdef LOAD_UNIT_MISALIGNED_EN
   assign need2    = (f3_q == FNC_LW && off_q != 2'd0) ||
                     ((f3_q == FNC_LH || f3_q == FNC_LHU) && off_q == 2'd3);
   assign mis_flag = 1'b0;
`else
   assign need2    = 1'b0;
   assign mis_flag = is_misaligned(f3_q, off_q);
`endif

   assign bus.req_ready       = state == ST_IDLE;
   assign bus.resp_valid      = state == ST_RESP;
   assign bus.resp_data       = data_q;
   assign bus.resp_rd         = rd_q;
   assign bus.resp_misaligned = mis_q;

   assign mem_en   = (state == ST_IDLE && bus.req_valid) || (state == ST_DATA1 && need2);
   assign mem_addr = state == ST_IDLE ? bus.req_addr[MEM_AWIDTH+1:2] : waddr_q + 1'b1;

   assign window = state == ST_DATA2 ? {mem_dout, word1_q} : {{DWIDTH{1'b0}}, mem_dout};

   load_extract u_extract (
      .func3  (f3_q),
      .offset (off_q),
      .window (window),
      .result (fmt)
   );

   // FSM: accept a request, gather one or two words, hold the formatted response until taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         f3_q    <= '0;
         off_q   <= '0;
         rd_q    <= '0;
         waddr_q <= '0;
         word1_q <= '0;
         data_q  <= '0;
         mis_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (bus.req_valid) begin
               f3_q    <= bus.req_func3;
               off_q   <= bus.req_addr[1:0];
               rd_q    <= bus.req_rd;
               waddr_q <= bus.req_addr[MEM_AWIDTH+1:2];
               state   <= ST_DATA1;
            end
            ST_DATA1: if (need2) begin
               word1_q <= mem_dout;
               state   <= ST_DATA2;
            end else begin
               data_q <= mis_flag ? '0 : fmt;
               mis_q  <= mis_flag;
               state  <= ST_RESP;
            end
            ST_DATA2: begin
               data_q <= fmt;
               mis_q  <= 1'b0;
               state  <= ST_RESP;
            end
            default: if (bus.resp_ready) state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: scoreboard bench for load_align_unit (honours LOAD_UNIT_MISALIGNED_EN)
module tb_load_align_unit;
   import load_align_unit_pkg::*;

`ifdef LOAD_UNIT_MISALIGNED_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        mis;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_en;
   logic [13:0] mem_addr;
   logic [31:0] mem_dout = '0;

   exp_t        sb[$];
   logic [13:0] rd_log[$];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   load_align_unit_if #(.DWIDTH(32), .TAG_W(5)) bus ();

   load_align_unit dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .mem_en   (mem_en),
      .mem_addr (mem_addr),
      .mem_dout (mem_dout)
   );

   function automatic logic [31:0] memval(logic [13:0] a);
      case (a)
         14'h0400: return 32'hDEADBEEF;
         14'h0401: return 32'h11223344;
         14'h3FFF: return 32'hA1B2C3D4;
         14'h0000: return 32'h55667788;
         default:  return {a, 2'b00, ~a, 2'b11};
      endcase
   endfunction

   always @(posedge clk) begin
      if (mem_en) begin
         mem_dout <= memval(mem_addr);
         rd_log.push_back(mem_addr);
      end
   end

   function automatic exp_t model(logic [2:0] f3, logic [31:0] addr, logic [4:0] rd);
      logic [13:0] wa = addr[15:2];
      int          o = int'(addr[1:0]);
      logic [63:0] pair;
      logic [7:0]  b[8];
      logic        misal;
      exp_t        e;
      pair = {memval(wa + 14'd1), memval(wa)};
      for (int i = 0; i < 8; i++) b[i] = pair[8*i +: 8];
      misal = ((f3 == 3'd1 || f3 == 3'd5) && o[0]) || (f3 == 3'd2 && o != 0);
      e.rd  = rd;
      e.mis = 1'b0;
      e.lat = (MIS_EN && misal && o != 1) || (MIS_EN && f3 == 3'd2 && o == 1) ? 3 : 2;
      if (!MIS_EN && misal) begin
         e.data = '0;
         e.mis  = 1'b1;
      end else begin
         case (f3)
            3'd0:    e.data = {{24{b[o][7]}}, b[o]};
            3'd4:    e.data = {24'h0, b[o]};
            3'd1:    e.data = {{16{b[o+1][7]}}, b[o+1], b[o]};
            3'd5:    e.data = {16'h0, b[o+1], b[o]};
            3'd2:    e.data = {b[o+3], b[o+2], b[o+1], b[o]};
            default: e.data = memval(wa);
         endcase
      end
      return e;
   endfunction

   task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                        output logic acc_en, output logic [13:0] acc_addr);
      int w = 0;
      while (!bus.req_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      if (!bus.req_ready) begin
         n_chk++; n_fail++;
         $display("FAIL issue_wait: req_ready=%b after %0d cycles, required 1", bus.req_ready, w);
      end
      rd_log.delete();
      bus.req_valid = 1'b1;
      bus.req_func3 = f3;
      bus.req_addr  = addr;
      bus.req_rd    = rd;
      #1;
      acc_en   = mem_en;
      acc_addr = mem_addr;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic collect(output logic [31:0] d, output logic [4:0] r, output logic m, output int lat);
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      if (!bus.resp_valid) begin
         n_chk++; n_fail++;
         $display("FAIL resp_wait: resp_valid=%b after %0d cycles, required 1", bus.resp_valid, lat);
      end
      d = bus.resp_data;
      r = bus.resp_rd;
      m = bus.resp_misaligned;
      if (bus.resp_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      n_chk += 6;
      if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
      if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
      if (bus.resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data got %h exp 0", bus.resp_data); end
      if (bus.resp_rd !== 5'h0) begin n_fail++; $display("FAIL reset_resp_rd got %h exp 0", bus.resp_rd); end
      if (bus.resp_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_resp_mis got %b exp 0", bus.resp_misaligned); end
      if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
   endtask

   task automatic test_aligned();
      logic [2:0]  f3[4]  = '{3'd0, 3'd4, 3'd1, 3'd5};
      logic [31:0] ad[4]  = '{32'h1003, 32'h1003, 32'h1002, 32'h1000};
      logic [31:0] ed[4]  = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
      logic [4:0]  tg[4]  = '{5'd3, 5'd17, 5'd9, 5'd30};
      logic        ae, m;
      logic [13:0] aa;
      logic [31:0] d;
      logic [4:0]  r;
      int          lat;
      exp_t        e;
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{data: ed[i], rd: tg[i], mis: 1'b0, lat: 2});
         issue(f3[i], ad[i], tg[i], ae, aa);
         collect(d, r, m, lat);
         e = sb.pop_front();
         n_chk += 6;
         if (ae !== 1'b1) begin n_fail++; $display("FAIL aligned%0d mem_en got %b exp 1", i, ae); end
         if (aa !== 14'h400) begin n_fail++; $display("FAIL aligned%0d mem_addr got %h exp 400", i, aa); end
         if (d !== e.data) begin n_fail++; $display("FAIL aligned%0d data got %h exp %h", i, d, e.data); end
         if (r !== e.rd) begin n_fail++; $display("FAIL aligned%0d rd got %h exp %h", i, r, e.rd); end
         if (m !== e.mis) begin n_fail++; $display("FAIL aligned%0d mis got %b exp %b", i, m, e.mis); end
         if (lat !== e.lat) begin n_fail++; $display("FAIL aligned%0d latency got %0d exp %0d", i, lat, e.lat); end
      end
   endtask

   task automatic test_backpressure();
      logic        ae, m;
      logic [13:0] aa;
      logic [31:0] d;
      logic [4:0]  r;
      int          lat;
      exp_t        e;
      bus.resp_ready = 1'b0;
      sb.push_back('{data: 32'hDEADBEEF, rd: 5'd12, mis: 1'b0, lat: 2});
      issue(3'd2, 32'h1000, 5'd12, ae, aa);
      collect(d, r, m, lat);
      e = sb.pop_front();
      n_chk += 3;
      if (d !== e.data) begin n_fail++; $display("FAIL bp_data got %h exp %h", d, e.data); end
      if (r !== e.rd) begin n_fail++; $display("FAIL bp_rd got %h exp %h", r, e.rd); end
      if (lat !== e.lat) begin n_fail++; $display("FAIL bp_latency got %0d exp %0d", lat, e.lat); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_chk += 3;
         if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d resp_valid got %b exp 1", i, bus.resp_valid); end
         if (bus.resp_data !== e.data) begin n_fail++; $display("FAIL bp_hold%0d data got %h exp %h", i, bus.resp_data, e.data); end
         if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d req_ready got %b exp 0", i, bus.req_ready); end
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      n_chk += 2;
      if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release req_ready got %b exp 1", bus.req_ready); end
      if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release resp_valid got %b exp 0", bus.resp_valid); end
   endtask

   task automatic test_split();
      logic [2:0]  f3[3] = '{3'd2, 3'd1, 3'd2};
      logic [31:0] ad[3] = '{32'h1002, 32'h1003, 32'hFFFD};
      logic [31:0] en[3] = '{32'h3344DEAD, 32'h000044DE, 32'h88A1B2C3};
      logic [13:0] a1[3] = '{14'h0400, 14'h0400, 14'h3FFF};
      logic [13:0] a2[3] = '{14'h0401, 14'h0401, 14'h0000};
      logic        ae, m;
      logic [13:0] aa;
      logic [31:0] d;
      logic [4:0]  r;
      int          lat;
      int          nrd;
      exp_t        e;
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{data: MIS_EN ? en[i] : 32'h0, rd: 5'(i + 20), mis: !MIS_EN, lat: MIS_EN ? 3 : 2});
         issue(f3[i], ad[i], 5'(i + 20), ae, aa);
         collect(d, r, m, lat);
         e = sb.pop_front();
         nrd = rd_log.size();
         n_chk += 7;
         if (d !== e.data) begin n_fail++; $display("FAIL split%0d data got %h exp %h", i, d, e.data); end
         if (r !== e.rd) begin n_fail++; $display("FAIL split%0d rd got %h exp %h", i, r, e.rd); end
         if (m !== e.mis) begin n_fail++; $display("FAIL split%0d mis got %b exp %b", i, m, e.mis); end
         if (lat !== e.lat) begin n_fail++; $display("FAIL split%0d latency got %0d exp %0d", i, lat, e.lat); end
         if (nrd !== (MIS_EN ? 2 : 1)) begin n_fail++; $display("FAIL split%0d reads got %0d exp %0d", i, nrd, MIS_EN ? 2 : 1); end
         if ((nrd > 0 ? rd_log[0] : 14'h0) !== a1[i]) begin n_fail++; $display("FAIL split%0d first_addr got %h exp %h", i, nrd > 0 ? rd_log[0] : 14'h0, a1[i]); end
         if ((nrd > 1 ? rd_log[1] : 14'h0) !== (MIS_EN ? a2[i] : 14'h0)) begin n_fail++; $display("FAIL split%0d second_addr got %h exp %h", i, nrd > 1 ? rd_log[1] : 14'h0, MIS_EN ? a2[i] : 14'h0); end
      end
   endtask

   task automatic test_sweep();
      logic        ae, m;
      logic [13:0] aa;
      logic [31:0] d;
      logic [31:0] addr;
      logic [4:0]  r;
      logic [4:0]  tag;
      int          lat;
      exp_t        e;
      for (int w = 0; w < 2; w++) begin
         for (int f = 0; f < 8; f++) begin
            for (int o = 0; o < 4; o++) begin
               addr = 32'h1000 + 32'(4 * w + o);
               tag  = 5'($urandom_range(0, 31));
               sb.push_back(model(3'(f), addr, tag));
               issue(3'(f), addr, tag, ae, aa);
               collect(d, r, m, lat);
               e = sb.pop_front();
               n_chk += 4;
               if (d !== e.data) begin n_fail++; $display("FAIL sweep f3=%0d a=%h data got %h exp %h", f, addr, d, e.data); end
               if (r !== e.rd) begin n_fail++; $display("FAIL sweep f3=%0d a=%h rd got %h exp %h", f, addr, r, e.rd); end
               if (m !== e.mis) begin n_fail++; $display("FAIL sweep f3=%0d a=%h mis got %b exp %b", f, addr, m, e.mis); end
               if (lat !== e.lat) begin n_fail++; $display("FAIL sweep f3=%0d a=%h latency got %0d exp %0d", f, addr, lat, e.lat); end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic        ae, m;
      logic [13:0] aa;
      logic [31:0] d;
      logic [4:0]  r;
      int          lat;
      exp_t        e;
      issue(3'd2, 32'h1002, 5'd7, ae, aa);
      @(posedge clk); #1;
      rst = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      n_chk += 3;
      if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst resp_valid got %b exp 0", bus.resp_valid); end
      if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst req_ready got %b exp 1", bus.req_ready); end
      if (bus.resp_rd !== 5'h0) begin n_fail++; $display("FAIL midrst resp_rd got %h exp 0", bus.resp_rd); end
      @(posedge clk); #1;
      sb.push_back('{data: 32'hDEADBEEF, rd: 5'd8, mis: 1'b0, lat: 2});
      issue(3'd2, 32'h1000, 5'd8, ae, aa);
      collect(d, r, m, lat);
      e = sb.pop_front();
      n_chk += 3;
      if (d !== e.data) begin n_fail++; $display("FAIL midrst_next data got %h exp %h", d, e.data); end
      if (r !== e.rd) begin n_fail++; $display("FAIL midrst_next rd got %h exp %h", r, e.rd); end
      if (lat !== e.lat) begin n_fail++; $display("FAIL midrst_next latency got %0d exp %0d", lat, e.lat); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_func3  = '0;
      bus.req_addr   = '0;
      bus.req_rd     = '0;
      bus.resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      test_aligned();
      test_backpressure();
      test_split();
      test_sweep();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Load-side counterpart of the store byte-mask path.
- Accepts a load request (funct3, byte address, rd tag) and issues synchronous word reads to data memory (1-cycle read latency).
- Extracts the byte/halfword/word and sign- or zero-extends it, then returns a registered response under a valid/ready handshake.
- Sits between the memory stage of the RISC-V core and the DMEM/BIOS read ports.

Parameters:
DWIDTH, 32, data word width (fixed at 32 for RV32)
MEM_AWIDTH, 14, word-address width of the memory port
TAG_W, 5, width of the rd tag carried with the request

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
req_valid  input  1  load request present
req_ready  output  1  unit can accept a request
req_func3  input  3  load funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5)
req_addr  input  32  byte address
req_rd  input  TAG_W  destination register tag
mem_en  output  1  memory read enable
mem_addr  output  MEM_AWIDTH  word address to memory
mem_dout  input  DWIDTH  read data, valid one cycle after mem_en
resp_valid  output  1  response valid
resp_ready  input  1  consumer accepts response
resp_data  output  DWIDTH  aligned, extended load result
resp_rd  output  TAG_W  tag of the response
resp_misaligned  output  1  misaligned access flagged

Behaviour:
- States: IDLE, DATA1, DATA2, RESP. Reset (rst=0, async) forces IDLE and clears resp_valid, resp_data, resp_rd, resp_misaligned and all latched request fields to 0.
- req_ready = (state==IDLE). Accept when req_valid && req_ready: latch func3, addr[1:0], rd and word address; go to DATA1.
- mem_en = 1 and mem_addr = req_addr[MEM_AWIDTH+1:2], driven combinationally in IDLE when req_valid is high; otherwise mem_en = 0.
- DATA1: mem_dout is the first word.
  - If the access needs no second word: format the result into the output registers and go to RESP.
  - Otherwise (feature-dependent, see below) issue the second read and go to DATA2.
- DATA2: mem_dout is the second word. Merge, format, go to RESP.
- RESP: resp_valid = 1; outputs are held stable while resp_ready = 0. On resp_ready, go to IDLE and drop resp_valid.
- Latency: aligned access gives resp_valid 2 cycles after acceptance; a split access gives 3. No new request is accepted before the response handshake completes.
- Extraction, using offset = addr[1:0]:
  - LB/LBU select byte (offset).
  - LH/LHU select bytes offset..offset+1.
  - LB/LH sign-extend from the top selected bit; LBU/LHU zero-extend.
- Misaligned means LH/LHU with offset[0]=1, or LW with offset != 0.
- Illegal funct3 (3, 6, 7): return the raw first word, resp_misaligned = 0.
- Word-address wrap: the second read address is first word + 1, modulo 2^MEM_AWIDTH.
- Reset asserted in any state: immediate return to IDLE; the in-flight read is discarded.

Optional Feature:
- Macro: LOAD_UNIT_MISALIGNED_EN.
- Defined:
  - LH at offset 1 is extracted from a single word.
  - LH at offset 3 and LW at offset 1/2/3 perform a second read in DATA2. The result is taken from the 64-bit {word2, word1} shifted right by 8*offset, then extended.
  - resp_misaligned = 0.
- Undefined:
  - DATA2 is unreachable.
  - Any misaligned access goes DATA1 -> RESP with resp_data = 0 and resp_misaligned = 1.

Decomposition:
- Shared header/package holds the FNC_LB/LH/LW/LBU/LHU funct3 constants (same header as the store funct3 codes) and the 2-bit state encoding.
- One combinational sub-module, load_extract: inputs func3, offset and a 64-bit window; output is the extended 32-bit result.
- The FSM, handshake and registers stay in load_align_unit.

Test Plan:
Memory preload: word 0x400 = 0xDEADBEEF, word 0x401 = 0x11223344.
- LB 0x1003 -> 0xFFFFFFDE; LBU 0x1003 -> 0x000000DE; mem_addr = 0x400 on the accept cycle, resp_valid 2 cycles later.
- LH 0x1002 -> 0xFFFFDEAD; LHU 0x1000 -> 0x0000BEEF; resp_rd equals the request tag.
- LW 0x1000 with resp_ready held 0 for 3 cycles -> resp_data = 0xDEADBEEF stable throughout, req_ready = 0 until the handshake completes, then 1.
- LW 0x1002:
  - With macro: reads 0x400 then 0x401, resp_data = 0x3344DEAD 3 cycles after accept.
  - Without macro: resp_data = 0, resp_misaligned = 1, single read.
- LH 0x1003 with macro -> 0x000044DE. Wrap: LW at word 0x3FFF offset 1 -> second read at word 0x0000.
- rst pulsed low while in DATA2 -> resp_valid = 0 and req_ready = 1 immediately after release; the next LW 0x1000 returns 0xDEADBEEF.
